// File: rtl/fir_mac_sched.sv
// fir_mac_sched: 6-tap FIR with one multiplier and one adder in a 2-stage pipeline.
// Result is valid 7 edges after accept and is held until out_ready. Optional macro FIR_MAC_SCHED_SCALE_EN.
module fir_mac_sched #(
  parameter int DATA_W    = 32,
  parameter int COEF_FRAC = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  input  logic [DATA_W-1:0] x4,
  input  logic [DATA_W-1:0] x5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [2:0]        tap_idx
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DRAIN, S_DONE} state_t;

  localparam logic signed [DATA_W-1:0] C_OUTER = DATA_W'(-276);
  localparam logic signed [DATA_W-1:0] C_MID   = DATA_W'(1163);
  localparam logic signed [DATA_W-1:0] C_INNER = DATA_W'(1819);

`ifdef FIR_MAC_SCHED_SCALE_EN
  localparam bit SCALE_EN = 1'b1;
`else
  localparam bit SCALE_EN = 1'b0;
`endif

  state_t                    r_state;
  logic [2:0]                r_idx;
  logic signed [DATA_W-1:0]  r_x [6];
  logic signed [DATA_W-1:0]  r_prod;
  logic signed [DATA_W-1:0]  r_acc;
  logic signed [DATA_W-1:0]  r_out;
  logic                      r_out_vld;

  logic signed [DATA_W-1:0]  w_x;
  logic signed [DATA_W-1:0]  w_c;
  logic signed [DATA_W-1:0]  w_prod;
  logic signed [DATA_W-1:0]  w_sum;
  logic signed [DATA_W-1:0]  w_out;

  always_comb begin
    w_x = r_x[0];
    w_c = C_OUTER;
    case (r_idx)
      3'd1:    begin w_x = r_x[1]; w_c = C_MID;   end
      3'd2:    begin w_x = r_x[2]; w_c = C_INNER; end
      3'd3:    begin w_x = r_x[3]; w_c = C_INNER; end
      3'd4:    begin w_x = r_x[4]; w_c = C_MID;   end
      3'd5:    begin w_x = r_x[5]; w_c = C_OUTER; end
      default: begin w_x = r_x[0]; w_c = C_OUTER; end
    endcase
  end

  // Same-width multiply keeps only the low DATA_W bits of the product (wraps).
  assign w_prod = w_x * w_c;
  assign w_sum  = r_acc + r_prod;
  assign w_out  = SCALE_EN ? (w_sum >>> COEF_FRAC) : w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      for (int i = 0; i < 6; i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x[0]  <= x0;
            r_x[1]  <= x1;
            r_x[2]  <= x2;
            r_x[3]  <= x3;
            r_x[4]  <= x4;
            r_x[5]  <= x5;
            r_acc   <= '0;
            r_idx   <= 3'd0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod <= w_prod;
          // The first product has nothing before it to accumulate.
          if (r_idx != 3'd0) r_acc <= w_sum;
          if (r_idx == 3'd5) begin
            r_idx   <= 3'd0;
            r_state <= S_DRAIN;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_DRAIN: begin
          r_out     <= w_out;
          r_out_vld <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign tap_idx   = r_idx;
  assign out_valid = r_out_vld;
  assign out_data  = r_out;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: table of sample sets plus hold, back-to-back,
// async-reset and wrap sequences; expectations are hand-computed raw or scaled sums.
module tb_fir_mac_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [5:0][31:0] xin;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  logic [2:0]       tap_idx;

  fir_mac_sched #(.DATA_W(32), .COEF_FRAC(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(xin[0]), .x1(xin[1]), .x2(xin[2]), .x3(xin[3]), .x4(xin[4]), .x5(xin[5]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .tap_idx(tap_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][31:0] x;
    logic [31:0]      raw;
    logic [31:0]      scl;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          acc_t[$];
  logic [31:0] res_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_t.push_back(cyc);
      if (out_valid && out_ready) res_q.push_back(out_data);
    end
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, want finish before 300us");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] raw, input logic [31:0] scl);
`ifdef FIR_MAC_SCHED_SCALE_EN
    return scl;
`else
    return raw;
`endif
  endfunction

  function automatic logic [5:0][31:0] all_of(input logic [31:0] v);
    logic [5:0][31:0] r;
    for (int i = 0; i < 6; i++) r[i] = v;
    return r;
  endfunction

  // Accept one set, then follow it to out_valid checking latency, tap sequence and data.
  task automatic send(input logic [5:0][31:0] v, input logic [31:0] exp, input string tag);
    int lat;
    int n;
    bit tap_ok;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    xin = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    xin = all_of(32'hDEAD_BEEF);
    tap_ok = (tap_idx === 3'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat <= 5) begin
        if (tap_idx !== lat[2:0]) tap_ok = 1'b0;
      end else if (tap_idx !== 3'd0) begin
        tap_ok = 1'b0;
      end
      if (out_valid) break;
    end
    chk({tag, "_latency"}, lat, 32'd7);
    chk({tag, "_taps"}, {31'd0, tap_ok}, 32'd1);
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic back_to_idle(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_vld"}, {31'd0, out_valid}, 32'd0);
  endtask

  vec_t tbl[7];
  int   n;
  int   nacc;

  initial begin
    tbl[0].x = all_of(32'd1);            tbl[0].raw = 32'd5412;      tbl[0].scl = 32'd1;
    tbl[1].x = '0; tbl[1].x[1] = 32'd1000; tbl[1].raw = 32'd1163000; tbl[1].scl = 32'd283;
    tbl[2].x = '0; tbl[2].x[0] = 32'd1000; tbl[2].raw = 32'(-276000); tbl[2].scl = 32'(-68);
    tbl[3].x = all_of(32'd4096);         tbl[3].raw = 32'd22167552;  tbl[3].scl = 32'd5412;
    for (int i = 0; i < 6; i++) tbl[4].x[i] = 32'(i + 1);
    tbl[4].raw = 32'd18942;              tbl[4].scl = 32'd4;
    tbl[5].x = all_of(32'hFFFF_FFFF);    tbl[5].raw = 32'(-5412);    tbl[5].scl = 32'(-2);
    // Each truncated product is 2^31-1819, so the pair wraps to -3638.
    tbl[6].x = '0; tbl[6].x[2] = 32'h7FFF_FFFF; tbl[6].x[3] = 32'h7FFF_FFFF;
    tbl[6].raw = 32'hFFFF_F1CA;          tbl[6].scl = 32'hFFFF_FFFF;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    xin = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tap_idx", {29'd0, tap_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].x, pick(tbl[i].raw, tbl[i].scl), $sformatf("vec%0d", i));
      back_to_idle($sformatf("vec%0d", i));
    end

    // Consumer stall: result and state hold, new requests are refused.
    out_ready = 1'b0;
    send(all_of(32'd4096), pick(32'd22167552, 32'd5412), "hold");
    nacc = acc_t.size();
    xin = all_of(32'd7);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_vld", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_data", i), out_data, pick(32'd22167552, 32'd5412));
      chk($sformatf("hold%0d_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("hold%0d_rdy", i), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    back_to_idle("hold");
    chk("hold_keep_data", out_data, pick(32'd22167552, 32'd5412));
    chk("hold_no_accept", acc_t.size(), nacc);

    // Back-to-back with in_valid held high.
    acc_t.delete();
    res_q.delete();
    @(negedge clk);
    xin = all_of(32'd1);
    in_valid = 1'b1;
    n = 0;
    while (acc_t.size() < 1 && n < 30) begin @(posedge clk); #1; n++; end
    xin = all_of(32'd4096);
    n = 0;
    while (acc_t.size() < 2 && n < 30) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 30) begin @(posedge clk); #1; n++; end
    chk("b2b_accepts", acc_t.size(), 32'd2);
    chk("b2b_results", res_q.size(), 32'd2);
    if (acc_t.size() == 2) chk("b2b_spacing", acc_t[1] - acc_t[0], 32'd9);
    if (res_q.size() == 2) begin
      chk("b2b_res_a", res_q[0], pick(32'd5412, 32'd1));
      chk("b2b_res_b", res_q[1], pick(32'd22167552, 32'd5412));
    end

    // Asynchronous reset in the middle of the multiply phase.
    res_q.delete();
    @(negedge clk);
    xin = all_of(32'd1000);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (tap_idx !== 3'd3 && n < 10) begin @(posedge clk); #1; n++; end
    chk("arst_reached_tap3", {29'd0, tap_idx}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_tap_idx", {29'd0, tap_idx}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(all_of(32'd1), pick(32'd5412, 32'd1), "post_rst");
    back_to_idle("post_rst");
    chk("post_rst_results", res_q.size(), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
